// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period helper.
// Used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clocks per bit; integer divide, valid range 2..65535.
   function automatic int bps_cnt(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/uart_bps_tick.sv
// Bit-period counter: counts 0..BPS_CNT-1 and flags the last clock of each bit.
// Held at zero while clr is high so the first bit after a clear is a full period.
module uart_bps_tick #(
   parameter int BPS_CNT = 5208
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(BPS_CNT - 1);

   logic [15:0] clk_cnt;

   assign tick = (clk_cnt == LAST);

   // Free-running bit-period counter, wraps on the end-of-bit clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt <= '0;
      end else if (clr || tick) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/uart_send.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs come straight from flops so the TX pin never glitches.
module uart_send
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       uart_tx
);

   localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);

   // Out-of-range settings fall back to no parity / one stop bit.
   localparam int PAR_EFF  = (PARITY == PAR_ODD || PARITY == PAR_EVEN) ? PARITY : PAR_NONE;
   localparam int STOP_EFF = (STOP_BITS == 2) ? 2 : 1;
   localparam logic [2:0] STOP_LAST = 3'(STOP_EFF - 1);

   uart_state_e state_q, state_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  byte_q, byte_d;
   logic        par_q, par_d;
   logic        tx_d, ready_d, done_d;
   logic        cnt_clr, tick;

   uart_bps_tick #(
      .BPS_CNT (BPS_CNT)
   ) u_bps_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .tick  (tick)
   );

   // State, latched byte and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         bit_q    <= '0;
         byte_q   <= '0;
         par_q    <= 1'b0;
         uart_tx  <= 1'b1;
         tx_ready <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         par_q    <= par_d;
         uart_tx  <= tx_d;
         tx_ready <= ready_d;
         tx_done  <= done_d;
      end
   end

   // Next-state logic; each bit state advances only on the end-of-bit tick.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      par_d   = par_q;
      tx_d    = uart_tx;
      ready_d = 1'b0;
      done_d  = 1'b0;
      cnt_clr = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            ready_d = 1'b1;
            tx_d    = 1'b1;
            if (tx_en && tx_ready) begin
               byte_d  = tx_data;
               par_d   = (PAR_EFF == PAR_ODD) ? ~^tx_data : ^tx_data;
               bit_d   = '0;
               state_d = ST_START;
               tx_d    = 1'b0;
               ready_d = 1'b0;
            end
         end

         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               bit_d   = '0;
               tx_d    = byte_q[0];
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (PAR_EFF != PAR_NONE) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = byte_q[bit_q + 3'd1];
               end
            end
         end

         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end

         ST_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (bit_q == STOP_LAST) begin
                  state_d = ST_IDLE;
                  bit_d   = '0;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: five instances (8N1, 8E1, 8O1, 8N2, out-of-range settings)
// checked cycle by cycle against a frame model built from the bit-level rules.
module tb_uart_send;

   localparam int BPS = 10;   // 1 MHz / 100 kbaud
   localparam int N   = 5;

   // Effective framing of each instance: parity mode (0 none, 1 odd, 2 even), stop bits.
   int par_m [N] = '{0, 2, 1, 0, 0};
   int stp_m [N] = '{1, 1, 1, 2, 1};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] en = '0;
   logic [7:0]   dat [N];
   logic [N-1:0] rdy, dn, line;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .tx_en(en[0]), .tx_data(dat[0]),
      .tx_ready(rdy[0]), .tx_done(dn[0]), .uart_tx(line[0]));
   uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .tx_en(en[1]), .tx_data(dat[1]),
      .tx_ready(rdy[1]), .tx_done(dn[1]), .uart_tx(line[1]));
   uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .tx_en(en[2]), .tx_data(dat[2]),
      .tx_ready(rdy[2]), .tx_done(dn[2]), .uart_tx(line[2]));
   uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .rst_n(rst_n), .tx_en(en[3]), .tx_data(dat[3]),
      .tx_ready(rdy[3]), .tx_done(dn[3]), .uart_tx(line[3]));
   uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(3), .STOP_BITS(3)) u_bad (
      .clk(clk), .rst_n(rst_n), .tx_en(en[4]), .tx_data(dat[4]),
      .tx_ready(rdy[4]), .tx_done(dn[4]), .uart_tx(line[4]));

   // Frame length in clocks from accept to tx_ready high.
   function automatic int flen(input int i);
      return BPS * (1 + 8 + ((par_m[i] != 0) ? 1 : 0) + stp_m[i]);
   endfunction

   // Expected line level c clocks after accept: start, data LSB first, parity, stop.
   function automatic logic exp_bit(input int i, input logic [7:0] b, input int c);
      int k;
      k = c / BPS;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (par_m[i] != 0 && k == 9) begin
         if (par_m[i] == 1) return ($countones(b) % 2) == 0;  // odd: total ones odd
         else               return ($countones(b) % 2) == 1;  // even: total ones even
      end
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
      nvec++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s: observed {tx,ready,done}=%b expected %b", tag, obs, exp_v);
      end
   endtask

   // Send one byte on instance i and check every clock through the tx_done cycle.
   // accepted: the accept edge has already happened (back-to-back second byte).
   // hold: keep tx_en high and present nb at the end so it is taken immediately.
   // poke_at: cycle at which a stray tx_en with 0xFF is pulsed mid-frame (-1 = none).
   task automatic frame(input int i, input logic [7:0] b, input bit accepted,
                        input bit hold, input logic [7:0] nb, input int poke_at);
      int len;
      logic [2:0] e;
      len = flen(i);
      if (!accepted) begin
         @(negedge clk);
         chk($sformatf("idle i%0d", i), {line[i], rdy[i], dn[i]}, 3'b110);
         en[i]  = 1'b1;
         dat[i] = b;
         @(posedge clk);
      end
      for (int c = 0; c <= len; c++) begin
         @(negedge clk);
         e = (c < len) ? {exp_bit(i, b, c), 2'b00} : 3'b111;
         chk($sformatf("i%0d byte%02h c%0d", i, b, c), {line[i], rdy[i], dn[i]}, e);
         if (!hold) en[i] = (c == poke_at);
         if (c == poke_at)          dat[i] = 8'hFF;
         else if (hold && c == len) dat[i] = nb;
         else                       dat[i] = 8'($urandom);
      end
   endtask

   initial begin
      logic [7:0] b, b2;
      for (int i = 0; i < N; i++) dat[i] = 8'h00;

      // Reset state on every instance
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++)
         chk($sformatf("reset i%0d", i), {line[i], rdy[i], dn[i]}, 3'b110);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++)
         chk($sformatf("post_reset i%0d", i), {line[i], rdy[i], dn[i]}, 3'b110);

      // Directed frames
      frame(0, 8'hA5, 0, 0, 8'h00, -1);   // 8N1
      frame(1, 8'h07, 0, 0, 8'h00, -1);   // even parity -> 1
      frame(2, 8'h07, 0, 0, 8'h00, -1);   // odd parity -> 0
      frame(3, 8'h00, 0, 0, 8'h00, -1);   // two stop bits
      frame(4, 8'hA5, 0, 0, 8'h00, -1);   // out-of-range settings act as 8N1
      frame(0, 8'h00, 0, 0, 8'h00, 30);   // stray tx_en 0xFF mid-frame ignored

      // Back-to-back with tx_en held high
      frame(0, 8'h55, 0, 1, 8'hAA, -1);
      frame(0, 8'hAA, 1, 0, 8'h00, -1);
      b  = 8'($urandom);
      b2 = 8'($urandom);
      frame(3, b, 0, 1, b2, -1);
      frame(3, b2, 1, 0, 8'h00, -1);
      b  = 8'($urandom);
      b2 = 8'($urandom);
      frame(1, b, 0, 1, b2, -1);
      frame(1, b2, 1, 0, 8'h00, -1);

      // Randomised bytes on every configuration, with random stray tx_en pulses
      for (int i = 0; i < N; i++)
         for (int r = 0; r < 3; r++)
            frame(i, 8'($urandom), 0, 0, 8'h00, (r == 2) ? int'($urandom_range(1, 80)) : -1);

      // Reset mid-frame: line must go high at once, no tx_done, then normal operation
      b = 8'($urandom) & 8'hF7;            // data bit 3 is on the line at clock 45
      @(negedge clk);
      en[0]  = 1'b1;
      dat[0] = b;
      @(posedge clk);
      for (int c = 0; c <= 45; c++) begin
         @(negedge clk);
         chk($sformatf("pre_abort c%0d", c), {line[0], rdy[0], dn[0]},
             {exp_bit(0, b, c), 2'b00});
         en[0]  = 1'b0;
         dat[0] = 8'($urandom);
      end
      rst_n = 1'b0;
      #1;
      chk("abort_async", {line[0], rdy[0], dn[0]}, 3'b110);
      repeat (3) @(negedge clk);
      chk("abort_held", {line[0], rdy[0], dn[0]}, 3'b110);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         chk($sformatf("after_abort c%0d", c), {line[0], rdy[0], dn[0]}, 3'b110);
      end
      frame(0, 8'h3C, 0, 0, 8'h00, -1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
